// File: rtl/cia_access_sched.sv
// Shares one mos6526 register port between the CPU (always first) and a queued auxiliary requester.
// Optional macro CIA_SCHED_ICR_GUARD_EN suppresses auxiliary reads of the ICR (rs=0xD).
module cia_access_sched #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic       phi2_n,
  input  logic       cpu_cs_n,
  input  logic       cpu_rw,
  input  logic [3:0] cpu_rs,
  input  logic [7:0] cpu_di,
  input  logic       aux_valid,
  output logic       aux_ready,
  input  logic       aux_rw,
  input  logic [3:0] aux_rs,
  input  logic [7:0] aux_di,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_blocked,
  output logic       cia_cs_n,
  output logic       cia_rw,
  output logic [3:0] cia_rs,
  output logic [7:0] cia_db_in,
  input  logic [7:0] cia_db_out,
  output logic [7:0] starve_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DepthCnt = FIFO_DEPTH[PW:0];

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  state_e        state_q, state_d;
  logic [12:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          aux_ready_q;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_blocked_q, rsp_blocked_d;
  logic [7:0]    starve_q, starve_d;
  logic          push, pop, issue;
  logic [12:0]   head;
  logic          head_rw, head_blocked;
  logic [3:0]    head_rs;
  logic [7:0]    head_di;

  assign push    = aux_valid & aux_ready_q;
  assign head    = fifo_mem[rd_ptr_q];
  assign head_rw = head[12];
  assign head_rs = head[11:8];
  assign head_di = head[7:0];

`ifdef CIA_SCHED_ICR_GUARD_EN
  // Reading the ICR clears pending interrupts the CPU has not seen yet.
  assign head_blocked = head_rw && (head_rs == 4'hD);
`else
  assign head_blocked = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    issue         = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_blocked_d = rsp_blocked_q;
    starve_d      = starve_q;
    unique case (state_q)
      StIdle: begin
        if (phi2_p && (cnt_q != '0)) state_d = StArmed;
      end
      StArmed: begin
        if (phi2_n) begin
          if (!cpu_cs_n) begin
            if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;
          end else begin
            starve_d = 8'd0;
            if (head_blocked) begin
              pop           = 1'b1;
              rsp_valid_d   = 1'b1;
              rsp_data_d    = 8'h00;
              rsp_blocked_d = 1'b1;
              state_d       = StIdle;
            end else if (head_rw) begin
              issue   = 1'b1;
              state_d = StCapture;
            end else begin
              issue         = 1'b1;
              pop           = 1'b1;
              rsp_valid_d   = 1'b1;
              rsp_data_d    = 8'h00;
              rsp_blocked_d = 1'b0;
              state_d       = StIdle;
            end
          end
        end
      end
      StCapture: begin
        pop           = 1'b1;
        rsp_valid_d   = 1'b1;
        rsp_data_d    = cia_db_out;
        rsp_blocked_d = 1'b0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      aux_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_blocked_q <= 1'b0;
      starve_q      <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      aux_ready_q   <= (cnt_d != DepthCnt);
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_blocked_q <= rsp_blocked_d;
      starve_q      <= starve_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {aux_rw, aux_rs, aux_di};
  end

  // Port mux is combinational so the CPU and the single-clk aux strobe reach the CIA undelayed.
  always_comb begin
    cia_cs_n  = 1'b1;
    cia_rw    = cpu_rw;
    cia_rs    = cpu_rs;
    cia_db_in = cpu_di;
    if (!res_n) begin
      cia_rw    = 1'b1;
      cia_rs    = 4'h0;
      cia_db_in = 8'h00;
    end else if (!cpu_cs_n) begin
      cia_cs_n = 1'b0;
    end else if (issue) begin
      cia_cs_n  = 1'b0;
      cia_rw    = head_rw;
      cia_rs    = head_rs;
      cia_db_in = head_di;
    end
  end

  assign aux_ready   = aux_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_blocked = rsp_blocked_q;
  assign starve_cnt  = starve_q;

endmodule
